// File: rtl/bus_x_pkg.sv
// Shared types and widths for the bus_x near/far bridge.
package bus_x_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FAR_REQ = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/bus_x.sv
// Registered bridge: latches a near request, replays it as a four-phase
// far handshake, and returns a one-cycle completion pulse to the master.
module bus_x
    import bus_x_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clock_far,
    input  logic              i_request,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_far_request,
    output logic              o_far_rw,
    output logic [ADDR_W-1:0] o_far_address,
    output logic [DATA_W-1:0] o_far_wdata,
    input  logic [DATA_W-1:0] i_far_rdata,
    input  logic              i_far_ready
);

    // The far clock is kept only so existing instantiations still connect.
    logic unused_far_clock;
    assign unused_far_clock = i_clock_far;

    state_e            state_q, state_d;
    logic              far_req_q, far_req_d;
    logic              ready_q, ready_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d   = state_q;
        far_req_d = far_req_q;
        ready_d   = 1'b0;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_request) begin
                    rw_d      = i_rw;
                    addr_d    = i_address;
                    wdata_d   = i_wdata;
                    far_req_d = 1'b1;
                    state_d   = FAR_REQ;
                end
            end
            FAR_REQ: begin
                if (i_far_ready) begin
                    far_req_d = 1'b0;
                    ready_d   = 1'b1;
                    if (!rw_q) begin
                        rdata_d = i_far_rdata;
                    end
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for both sides to go quiet so a stale ready or a
                // still-held request cannot launch a second transfer.
                if (!i_far_ready && !i_request) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                far_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            far_req_q <= 1'b0;
            ready_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            far_req_q <= far_req_d;
            ready_q   <= ready_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_rdata       = rdata_q;
    assign o_ready       = ready_q;
    assign o_far_request = far_req_q;
    assign o_far_rw      = rw_q;
    assign o_far_address = addr_q;
    assign o_far_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_x.sv
// Self-checking bench for bus_x: directed handshake scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_bus_x;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_clock_far = 1'b0;
    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_far_request;
    logic        o_far_rw;
    logic [31:0] o_far_address;
    logic [31:0] o_far_wdata;
    logic [31:0] i_far_rdata;
    logic        i_far_ready;

    bus_x dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_clock_far   (i_clock_far),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_far_request (o_far_request),
        .o_far_rw      (o_far_rw),
        .o_far_address (o_far_address),
        .o_far_wdata   (o_far_wdata),
        .i_far_rdata   (i_far_rdata),
        .i_far_ready   (i_far_ready)
    );

    always #5 i_clock = ~i_clock;
    always #7 i_clock_far = ~i_clock_far;

    int checks = 0;
    int errors = 0;

    // Reference model: what the bridge should present, per transaction.
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic model_reset();
        m_rw    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, ".far_rw"},   {31'd0, o_far_rw}, {31'd0, m_rw});
        chk({tag, ".far_addr"}, o_far_address, m_addr);
        chk({tag, ".far_wdata"}, o_far_wdata, m_wdata);
        chk({tag, ".rdata"},    o_rdata, m_rdata);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"},   {31'd0, o_ready}, 32'd0);
        chk({tag, ".far_req"}, {31'd0, o_far_request}, 32'd0);
        chk_fields(tag);
    endtask

    // One full transaction. d = idle cycles before the far slave answers,
    // fh/rh = extra cycles far ready / near request stay high after o_ready.
    task automatic txn(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] frd,
                       input int d, input int fh, input int rh);
        int f;
        int r;
        i_request   = 1'b1;
        i_rw        = rw;
        i_address   = addr;
        i_wdata     = wd;
        i_far_ready = 1'b0;
        i_far_rdata = $urandom;
        tick();
        m_rw    = rw;
        m_addr  = addr;
        m_wdata = wd;
        // Master buses may wander once accepted; the latched copy must not.
        i_rw      = 1'($urandom);
        i_address = $urandom;
        i_wdata   = $urandom;
        for (int k = 0; k < d; k++) begin
            chk({tag, ".wait_ready"},   {31'd0, o_ready}, 32'd0);
            chk({tag, ".wait_far_req"}, {31'd0, o_far_request}, 32'd1);
            chk_fields({tag, ".wait"});
            i_far_rdata = $urandom;
            tick();
        end
        i_far_ready = 1'b1;
        i_far_rdata = frd;
        tick();
        if (!rw) m_rdata = frd;
        chk({tag, ".done_ready"},   {31'd0, o_ready}, 32'd1);
        chk({tag, ".done_far_req"}, {31'd0, o_far_request}, 32'd0);
        chk_fields({tag, ".done"});
        f = fh;
        r = rh;
        i_far_rdata = $urandom;
        i_far_ready = (f > 0);
        i_request   = (r > 0);
        while (f > 0 || r > 0) begin
            tick();
            chk({tag, ".hold_ready"},   {31'd0, o_ready}, 32'd0);
            chk({tag, ".hold_far_req"}, {31'd0, o_far_request}, 32'd0);
            chk({tag, ".hold_rdata"},   o_rdata, m_rdata);
            if (f > 0) f--;
            if (r > 0) r--;
            i_far_rdata = $urandom;
            i_far_ready = (f > 0);
            i_request   = (r > 0);
        end
        tick();
        chk_idle({tag, ".idle"});
    endtask

    initial begin
        i_reset     = 1'b1;
        i_request   = 1'b0;
        i_rw        = 1'b0;
        i_address   = '0;
        i_wdata     = '0;
        i_far_rdata = '0;
        i_far_ready = 1'b0;
        model_reset();

        // Reset held for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clock);
            chk_idle("reset");
        end
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("post_reset");
        end

        // Write with a one-cycle-lag far responder; rdata must stay 0.
        txn("write", 1'b1, 32'h1000_0005, 32'd100, 32'h5555_AAAA, 1, 0, 0);

        // Read with a three-cycle far delay; data held afterwards.
        txn("read", 1'b0, 32'h2000_0010, 32'h0, 32'hCAFE_F00D, 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("read_hold");
        end

        // Master keeps request high five cycles after o_ready.
        txn("req_hold", 1'b0, 32'h3000_0004, 32'h0, 32'h1234_5678, 1, 0, 5);

        // Far ready lingers four cycles; next request follows straight on.
        txn("far_hold", 1'b1, 32'h4000_0008, 32'hDEAD_BEEF, 32'h0, 1, 4, 0);
        txn("after_far_hold", 1'b0, 32'h4000_000C, 32'h0, 32'h0BAD_F00D, 1, 0, 0);

        // Far ready while idle is ignored.
        i_far_ready = 1'b1;
        i_far_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("idle_far_ready");
        end
        i_far_ready = 1'b0;
        tick();
        chk_idle("idle_far_ready_drop");

        // Reset asserted while waiting on the far slave.
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h5000_0000;
        i_wdata   = 32'h0;
        tick();
        chk("mid_reset.far_req_before", {31'd0, o_far_request}, 32'd1);
        #2;
        i_reset     = 1'b1;
        i_far_ready = 1'b1;
        i_far_rdata = 32'h7777_7777;
        #1;
        model_reset();
        chk("mid_reset.async_far_req", {31'd0, o_far_request}, 32'd0);
        chk_idle("mid_reset.async");
        @(negedge i_clock);
        chk_idle("mid_reset.held");
        i_request   = 1'b0;
        i_far_ready = 1'b0;
        i_reset     = 1'b0;
        tick();
        chk_idle("mid_reset.after");
        txn("post_reset_txn", 1'b0, 32'h5000_0004, 32'h0, 32'hA5A5_5A5A, 2, 0, 0);

        // Random transactions against the reference model.
        for (int n = 0; n < 25; n++) begin
            txn("rand", 1'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
